// File: rtl/ads868x_frame_packer.sv
// ADS868x frame packer: latches per-channel conversions into a shadow file and,
// once per tick period, streams a marker beat plus a 32-beat snapshot on AXI-Stream.
module ads868x_frame_packer #(
    parameter int unsigned C_TICK_PERIOD = 125000,
    parameter int unsigned C_N_CH        = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_sample_valid,
    input  logic [4:0]  s_sample_ch,
    input  logic [15:0] s_sample_data,
    output logic [55:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        frame_overrun,
    output logic [15:0] overrun_cnt
);
    localparam int            CW        = $clog2(C_TICK_PERIOD);
    localparam logic [CW-1:0] TICK_LAST = CW'(C_TICK_PERIOD - 1);
    localparam logic [4:0]    IDX_LAST  = 5'(C_N_CH - 1);

    typedef enum logic [1:0] {IDLE, MARK, DATA} state_t;

    logic [CW-1:0] tick_cnt_reg;
    logic          tick;
    state_t        state_reg, state_next;
    logic [4:0]    idx_reg, idx_next;
    logic [15:0]   seq_reg, seq_next, seq_inc;
    logic [55:0]   tdata_reg, tdata_next;
    logic          tvalid_reg, tvalid_next;
    logic          overrun_reg, overrun_next;
    logic [15:0]   ocnt_reg, ocnt_next;
    logic          snap_load;
    logic [15:0]   snap_data [C_N_CH];
    logic [C_N_CH-1:0] snap_fresh;
    logic [4:0]    rd_idx;
    logic [55:0]   data_beat;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + CW'(1);
        end
    end

    // Per-channel shadow and snapshot; a write in the snapshot cycle lands in
    // shadow only, so the snapshot sees the pre-write value.
    genvar gi;
    generate
        for (gi = 0; gi < C_N_CH; gi++) begin : g_ch
            logic        hit;
            logic [15:0] shadow_reg;
            logic        fresh_reg;
            logic [15:0] snap_reg;
            logic        snap_fresh_reg;

            assign hit = s_sample_valid && (s_sample_ch == 5'(gi));

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    shadow_reg     <= '0;
                    fresh_reg      <= 1'b0;
                    snap_reg       <= '0;
                    snap_fresh_reg <= 1'b0;
                end else begin
                    if (hit) begin
                        shadow_reg <= s_sample_data;
                    end
                    if (hit) begin
                        fresh_reg <= 1'b1;
                    end else if (snap_load) begin
                        fresh_reg <= 1'b0;
                    end
                    if (snap_load) begin
                        snap_reg       <= shadow_reg;
                        snap_fresh_reg <= fresh_reg;
                    end
                end
            end

            assign snap_data[gi]  = snap_reg;
            assign snap_fresh[gi] = snap_fresh_reg;
        end
    endgenerate

    // Next beat to load after a handshake: beat 0 after the marker, else idx+1.
    assign rd_idx    = (state_reg == MARK) ? 5'd0 : idx_reg + 5'd1;
    assign data_beat = {seq_reg, 15'd0, snap_fresh[rd_idx], 3'b000, rd_idx, snap_data[rd_idx]};
    assign seq_inc   = seq_reg + 16'd1;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        seq_next     = seq_reg;
        tdata_next   = tdata_reg;
        tvalid_next  = tvalid_reg;
        overrun_next = 1'b0;
        ocnt_next    = ocnt_reg;
        snap_load    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (tick) begin
                    snap_load   = 1'b1;
                    seq_next    = seq_inc;
                    state_next  = MARK;
                    tvalid_next = 1'b1;
                    tdata_next  = {seq_inc, 15'd0, 1'b0, 8'hFF, seq_inc};
                end
            end
            MARK: begin
                if (m_axis_tready) begin
                    state_next = DATA;
                    idx_next   = 5'd0;
                    tdata_next = data_beat;
                end
            end
            DATA: begin
                if (m_axis_tready) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next  = IDLE;
                        tvalid_next = 1'b0;
                    end else begin
                        idx_next   = rd_idx;
                        tdata_next = data_beat;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (tick && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
            if (ocnt_reg != 16'hFFFF) begin
                ocnt_next = ocnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            seq_reg     <= '0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            overrun_reg <= 1'b0;
            ocnt_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            seq_reg     <= seq_next;
            tdata_reg   <= tdata_next;
            tvalid_reg  <= tvalid_next;
            overrun_reg <= overrun_next;
            ocnt_reg    <= ocnt_next;
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign frame_overrun = overrun_reg;
    assign overrun_cnt   = ocnt_reg;
endmodule

// File: tb/tb_ads868x_frame_packer.sv
// Bench for ads868x_frame_packer: queue-based frame model checked every cycle,
// plus fixed-cycle literal expectations for the directed scenarios.
module tb_ads868x_frame_packer;
    localparam int P = 100;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_sample_valid = 1'b0;
    logic [4:0]  s_sample_ch = '0;
    logic [15:0] s_sample_data = '0;
    logic [55:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        frame_overrun;
    logic [15:0] overrun_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    ads868x_frame_packer #(.C_TICK_PERIOD(P), .C_N_CH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_sample_valid(s_sample_valid),
        .s_sample_ch   (s_sample_ch),
        .s_sample_data (s_sample_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_overrun (frame_overrun),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: shadow/fresh arrays, tick phase and a queue of expected beats.
    logic [15:0] m_shadow [32];
    logic [31:0] m_fresh;
    logic [15:0] m_seq;
    logic [15:0] m_ocnt;
    logic        m_ovr;
    int          m_tc;
    logic [55:0] q [$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_shadow[i] = '0;
        m_fresh = '0;
        m_seq   = '0;
        m_ocnt  = '0;
        m_ovr   = 1'b0;
        m_tc    = 0;
        q.delete();
    endtask

    initial begin : compare
        logic busy, hs, tick;
        model_reset();
        @(posedge aclk);
        forever begin
            @(negedge aclk);
            check("tvalid", 56'(m_axis_tvalid), 56'(q.size() > 0));
            if (q.size() > 0 && m_axis_tvalid) check("tdata", m_axis_tdata, q[0]);
            check("frame_overrun", 56'(frame_overrun), 56'(m_ovr));
            check("overrun_cnt", 56'(overrun_cnt), 56'(m_ocnt));
            if (q.size() > 0 && m_axis_tvalid && m_axis_tready)
                $display("beat seq=%0d idx=%02h fresh=%0d data=%04h", m_axis_tdata[55:40],
                         m_axis_tdata[23:16], m_axis_tdata[24], m_axis_tdata[15:0]);
            if (!aresetn) begin
                model_reset();
            end else begin
                busy  = (q.size() > 0);
                hs    = busy && m_axis_tready;
                tick  = (m_tc == P - 1);
                m_tc  = tick ? 0 : m_tc + 1;
                m_ovr = 1'b0;
                if (tick) begin
                    if (busy) begin
                        m_ovr = 1'b1;
                        if (m_ocnt != 16'hFFFF) m_ocnt = m_ocnt + 16'd1;
                    end else begin
                        m_seq = m_seq + 16'd1;
                        q.push_back({m_seq, 15'd0, 1'b0, 8'hFF, m_seq});
                        for (int i = 0; i < 32; i++)
                            q.push_back({m_seq, 15'd0, m_fresh[i], 8'(i), m_shadow[i]});
                        m_fresh = '0;
                    end
                end
                if (s_sample_valid) begin
                    m_shadow[s_sample_ch] = s_sample_data;
                    m_fresh[s_sample_ch]  = 1'b1;
                end
                if (hs) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
        s_sample_valid = 1'b0;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic write(input logic [4:0] ch, input logic [15:0] d);
        s_sample_valid = 1'b1;
        s_sample_ch    = ch;
        s_sample_data  = d;
    endtask

    initial begin : stim
        aresetn = 1'b0;
        m_axis_tready = 1'b1;
        step();
        step();
        check("rst_tvalid", 56'(m_axis_tvalid), 56'd0);
        check("rst_tdata", m_axis_tdata, 56'd0);
        check("rst_ovr", 56'(frame_overrun), 56'd0);
        check("rst_cnt", 56'(overrun_cnt), 56'd0);
        step();
        aresetn = 1'b1;
        cyc = 0;

        // Idle frame
        wait_until(99);  check("idle_pre_tick", 56'(m_axis_tvalid), 56'd0);
        wait_until(100); check("marker1_valid", 56'(m_axis_tvalid), 56'd1);
                         check("marker1", m_axis_tdata, 56'h0001_0000_FF_0001);
        wait_until(101); check("f1_beat0", m_axis_tdata, 56'h0001_0000_00_0000);
        wait_until(132); check("f1_beat31", m_axis_tdata, 56'h0001_0000_1F_0000);
        wait_until(133); check("f1_end", 56'(m_axis_tvalid), 56'd0);

        // Sample capture
        wait_until(150); write(5'd5, 16'h1234);
        wait_until(160); write(5'd31, 16'hBEEF);
        wait_until(206); check("f2_beat5", m_axis_tdata, 56'h0002_0001_05_1234);
        wait_until(232); check("f2_beat31", m_axis_tdata, 56'h0002_0001_1F_BEEF);

        // Write in the tick cycle
        wait_until(299); write(5'd3, 16'hAAAA);
        wait_until(304); check("f3_beat3", m_axis_tdata, 56'h0003_0000_03_0000);
        wait_until(306); check("f3_beat5", m_axis_tdata, 56'h0003_0000_05_1234);
        wait_until(404); check("f4_beat3", m_axis_tdata, 56'h0004_0001_03_AAAA);

        // Overrun: stall the marker across the next tick
        wait_until(500); m_axis_tready = 1'b0;
                         check("f5_marker", m_axis_tdata, 56'h0005_0000_FF_0005);
        wait_until(550); write(5'd7, 16'h7777);
        wait_until(599); check("ovr_pre", 56'(frame_overrun), 56'd0);
        wait_until(600); check("ovr_pulse", 56'(frame_overrun), 56'd1);
                         check("ovr_cnt1", 56'(overrun_cnt), 56'd1);
                         check("ovr_held", m_axis_tdata, 56'h0005_0000_FF_0005);
        wait_until(601); check("ovr_post", 56'(frame_overrun), 56'd0);
                         check("ovr_cnt_hold", 56'(overrun_cnt), 56'd1);
        wait_until(650); m_axis_tready = 1'b1;
        wait_until(708); check("f6_beat7", m_axis_tdata, 56'h0006_0001_07_7777);

        // Random backpressure and samples
        wait_until(800);
        while (cyc < 1400) begin
            step();
            m_axis_tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) write(5'($urandom_range(0, 31)), 16'($urandom));
        end
        m_axis_tready = 1'b1;

        // Reset mid-frame while data beat 10 is valid
        wait_until(1511);
        check("mid_valid", 56'(m_axis_tvalid), 56'd1);
        check("mid_idx", 56'(m_axis_tdata[23:16]), 56'h0A);
        aresetn = 1'b0;
        step();
        check("mid_rst_tvalid", 56'(m_axis_tvalid), 56'd0);
        check("mid_rst_tdata", m_axis_tdata, 56'd0);
        check("mid_rst_cnt", 56'(overrun_cnt), 56'd0);
        step();
        step();
        aresetn = 1'b1;
        cyc = 0;
        wait_until(99);  check("rel_pre_tick", 56'(m_axis_tvalid), 56'd0);
        wait_until(100); check("rel_marker", m_axis_tdata, 56'h0001_0000_FF_0001);
        wait_until(140);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
